// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: FSM state encodings and the
// memory-mapped address that load/store decodes to raise the write strobe.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [31:0] UART_ADDR = 32'h1000_0000;

    // Integer clocks-per-bit; the truncation matches what the baud counter uses.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// Small synchronous FIFO with a combinational head read. A push on full is
// ignored and a pop on empty is ignored; push and pop may occur together.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int         DEPTH_N = 1 << AW;
    localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [DEPTH_N];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; count tracks occupancy so full/empty are exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 transmitter: byte stores from load/store are queued in a FIFO
// and shifted out LSB first, so a store never has to wait for the line.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       uart_tx
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       sh, sh_n;
    logic             tx_bit;
    logic             pop;
    logic             empty;
    logic [7:0]       head;

    sync_fifo #(
        .DW(8),
        .AW(FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Next-state, bit timing and pop decision; the line level is computed here
    // and registered below so the pin never sees decode glitches.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt + 1'b1;
        bit_idx_n  = bit_idx;
        sh_n       = sh;
        tx_bit     = 1'b1;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_bit     = 1'b1;
                baud_cnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = head;
                    state_n = START;
                end
            end
            START: begin
                tx_bit = 1'b0;
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end
            end
            DATA: begin
                tx_bit = sh[bit_idx];
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                tx_bit = 1'b1;
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_n = '0;
                    state_n    = IDLE;
                end
            end
            default: begin
                state_n    = IDLE;
                baud_cnt_n = '0;
            end
        endcase
    end

    // State register; reset abandons any partial frame and forces the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            sh       <= sh_n;
            uart_tx  <= tx_bit;
            busy     <= !empty || (state != IDLE);
        end
    end

    // Sticky flag recording that a store was dropped because the FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based timeline model predicts the line,
// busy, full and overflow each cycle, and a line decoder recovers bytes.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int FIFO_AW  = 2;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int FRAME    = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, busy, overflow, uart_tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_tx_fifo #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .busy(busy),
        .overflow(overflow),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    // Reference model: pending bytes, the frame now on the line and its pop edge.
    byte unsigned mq[$];
    byte unsigned sent_q[$];
    byte unsigned frame_byte = 0;
    int  frame_pop = 0;
    bit  frame_valid = 0;
    int  free_edge = 0;
    bit  exp_ovf = 0;
    bit  busy_cond = 0;
    bit  exp_busy = 0;

    always @(posedge clk) begin
        int n;
        cyc = cyc + 1;
        if (rst) begin
            mq.delete();
            frame_valid = 0;
            free_edge   = 0;
            exp_ovf     = 0;
            busy_cond   = 0;
            exp_busy    = 0;
        end else begin
            n = mq.size();
            exp_busy = busy_cond;
            if (n > 0 && cyc >= free_edge) begin
                frame_byte  = mq.pop_front();
                frame_pop   = cyc;
                frame_valid = 1;
                free_edge   = cyc + FRAME + 1;
                sent_q.push_back(frame_byte);
            end
            if (wr_en) begin
                if (n == DEPTH) exp_ovf = 1;
                else mq.push_back(wr_data);
            end
            busy_cond = (mq.size() > 0) || (frame_valid && cyc <= frame_pop + FRAME - 1);
        end
    end

    function automatic bit exp_tx();
        int o;
        if (!frame_valid) return 1'b1;
        o = cyc - frame_pop - 1;
        if (o < 0 || o >= FRAME) return 1'b1;
        o = o / CPB;
        if (o == 0) return 1'b0;
        if (o == 9) return 1'b1;
        return frame_byte[o-1];
    endfunction

    function automatic bit exp_full();
        return mq.size() == DEPTH;
    endfunction

    // Line decoder: detects start bits and samples each bit mid-period.
    byte unsigned rx_q[$];
    int  starts[$];
    int  pos = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            pos = 0;
        end else if (pos == 0) begin
            if (uart_tx === 1'b0) begin
                pos = 1;
                starts.push_back(cyc);
            end
        end else begin
            if ((pos % CPB) == CPB / 2 && pos / CPB >= 1 && pos / CPB <= 8)
                rx_sh[pos/CPB-1] = uart_tx;
            if (pos == FRAME - CPB / 2 && uart_tx === 1'b1)
                rx_q.push_back(rx_sh);
            pos = (pos == FRAME - 1) ? 0 : pos + 1;
        end
    end

    task automatic clear_logs();
        rx_q.delete();
        sent_q.delete();
        starts.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx cyc=%0d got=%b exp=1", cyc, uart_tx); end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy cyc=%0d got=%b exp=0", cyc, busy); end
            checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full cyc=%0d got=%b exp=0", cyc, full); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf cyc=%0d got=%b exp=0", cyc, overflow); end
        end
    endtask

    task automatic test_single();
        int wr_edge = 0;
        clear_logs();
        for (int i = 0; i < FRAME + 20; i++) begin
            wr_en   = (i == 0);
            wr_data = 8'hA5;
            @(negedge clk);
            if (i == 0) wr_edge = cyc;
            checks++; if (uart_tx !== exp_tx()) begin errors++; $display("[TB] FAIL single_tx cyc=%0d got=%b exp=%b", cyc, uart_tx, exp_tx()); end
            checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
        end
        wr_en = 1'b0;
        checks++; if (starts.size() != 1 || starts[0] != wr_edge + 2) begin errors++; $display("[TB] FAIL single_latency starts=%0d first=%0d exp=%0d", starts.size(), (starts.size() > 0) ? starts[0] : -1, wr_edge + 2); end
        checks++; if (rx_q.size() != 1 || rx_q[0] != 8'hA5) begin errors++; $display("[TB] FAIL single_byte n=%0d got=%h exp=a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
    endtask

    task automatic test_fill();
        byte unsigned wb[4];
        clear_logs();
        for (int k = 0; k < 4; k++) wb[k] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4 * (FRAME + 1) + 20; i++) begin
            wr_en   = (i < 4);
            wr_data = (i < 4) ? wb[i] : 8'h00;
            @(negedge clk);
            checks++; if (uart_tx !== exp_tx()) begin errors++; $display("[TB] FAIL fill_tx cyc=%0d got=%b exp=%b", cyc, uart_tx, exp_tx()); end
            checks++; if (full !== exp_full()) begin errors++; $display("[TB] FAIL fill_full cyc=%0d got=%b exp=%b", cyc, full, exp_full()); end
            checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL fill_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
        end
        wr_en = 1'b0;
        checks++; if (rx_q.size() != 4) begin errors++; $display("[TB] FAIL fill_count got=%0d exp=4", rx_q.size()); end
        for (int k = 0; k < 4 && k < rx_q.size(); k++) begin
            checks++; if (rx_q[k] != wb[k]) begin errors++; $display("[TB] FAIL fill_byte%0d got=%h exp=%h", k, rx_q[k], wb[k]); end
        end
        for (int k = 1; k < starts.size(); k++) begin
            checks++; if (starts[k] - starts[k-1] != FRAME + 1) begin errors++; $display("[TB] FAIL fill_spacing%0d got=%0d exp=%0d", k, starts[k] - starts[k-1], FRAME + 1); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_overflow();
        byte unsigned wb[6];
        clear_logs();
        for (int k = 0; k < 6; k++) wb[k] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5 * (FRAME + 1) + 20; i++) begin
            wr_en   = (i < 6);
            wr_data = (i < 6) ? wb[i] : 8'h00;
            @(negedge clk);
            checks++; if (uart_tx !== exp_tx()) begin errors++; $display("[TB] FAIL ovf_tx cyc=%0d got=%b exp=%b", cyc, uart_tx, exp_tx()); end
            checks++; if (full !== exp_full()) begin errors++; $display("[TB] FAIL ovf_full cyc=%0d got=%b exp=%b", cyc, full, exp_full()); end
            checks++; if (overflow !== exp_ovf) begin errors++; $display("[TB] FAIL ovf_flag cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf); end
        end
        wr_en = 1'b0;
        checks++; if (rx_q.size() != 5) begin errors++; $display("[TB] FAIL ovf_frames got=%0d exp=5", rx_q.size()); end
        for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
            checks++; if (rx_q[k] != wb[k]) begin errors++; $display("[TB] FAIL ovf_byte%0d got=%h exp=%h", k, rx_q[k], wb[k]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_mid_frame();
        byte unsigned wb[3] = '{8'h00, 8'h11, 8'h22};
        clear_logs();
        for (int i = 0; i < 47; i++) begin
            wr_en   = (i < 3);
            wr_data = (i < 3) ? wb[i] : 8'h00;
            @(negedge clk);
            checks++; if (uart_tx !== exp_tx()) begin errors++; $display("[TB] FAIL mid_tx cyc=%0d got=%b exp=%b", cyc, uart_tx, exp_tx()); end
        end
        wr_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL mid_async_tx got=%b exp=1", uart_tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_busy got=%b exp=0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_ovf got=%b exp=0", overflow); end
        @(negedge clk);
        #2 rst = 1'b0;
        clear_logs();
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL mid_after_tx cyc=%0d got=%b exp=1", cyc, uart_tx); end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_busy cyc=%0d got=%b exp=0", cyc, busy); end
        end
        for (int i = 0; i < FRAME + 20; i++) begin
            wr_en   = (i == 0);
            wr_data = 8'h55;
            @(negedge clk);
            checks++; if (uart_tx !== exp_tx()) begin errors++; $display("[TB] FAIL mid_new_tx cyc=%0d got=%b exp=%b", cyc, uart_tx, exp_tx()); end
        end
        wr_en = 1'b0;
        checks++; if (rx_q.size() != 1 || rx_q[0] != 8'h55) begin errors++; $display("[TB] FAIL mid_new_byte n=%0d got=%h exp=55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        for (int i = 0; i < 2 * (FRAME + 1) + 20; i++) begin
            wr_en   = (i < 2);
            wr_data = (i == 0) ? 8'hFF : 8'h80;
            @(negedge clk);
            checks++; if (uart_tx !== exp_tx()) begin errors++; $display("[TB] FAIL b2b_tx cyc=%0d got=%b exp=%b", cyc, uart_tx, exp_tx()); end
            checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            checks++; if (full !== exp_full()) begin errors++; $display("[TB] FAIL b2b_full cyc=%0d got=%b exp=%b", cyc, full, exp_full()); end
        end
        wr_en = 1'b0;
        checks++; if (rx_q.size() != 2 || rx_q[0] != 8'hFF || rx_q[1] != 8'h80) begin errors++; $display("[TB] FAIL b2b_bytes n=%0d first=%h second=%h exp=ff,80", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, (rx_q.size() > 1) ? rx_q[1] : 8'h00); end
        checks++; if (starts.size() != 2 || starts[1] - starts[0] != FRAME + 1) begin errors++; $display("[TB] FAIL b2b_gap n=%0d spacing=%0d exp=%0d", starts.size(), (starts.size() > 1) ? starts[1] - starts[0] : -1, FRAME + 1); end
    endtask

    task automatic test_random();
        clear_logs();
        for (int i = 0; i < 1500; i++) begin
            wr_en   = (i < 900) && ($urandom_range(0, 99) < 3);
            wr_data = 8'($urandom_range(0, 255));
            @(negedge clk);
            checks++; if (uart_tx !== exp_tx()) begin errors++; $display("[TB] FAIL rand_tx cyc=%0d got=%b exp=%b", cyc, uart_tx, exp_tx()); end
            checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            checks++; if (full !== exp_full()) begin errors++; $display("[TB] FAIL rand_full cyc=%0d got=%b exp=%b", cyc, full, exp_full()); end
            checks++; if (overflow !== exp_ovf) begin errors++; $display("[TB] FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf); end
        end
        wr_en = 1'b0;
        checks++; if (rx_q.size() != sent_q.size()) begin errors++; $display("[TB] FAIL rand_count got=%0d exp=%0d", rx_q.size(), sent_q.size()); end
        for (int k = 0; k < rx_q.size() && k < sent_q.size(); k++) begin
            checks++; if (rx_q[k] != sent_q[k]) begin errors++; $display("[TB] FAIL rand_byte%0d got=%h exp=%h", k, rx_q[k], sent_q[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
